exe_vector_unit: RTL and testbench
==================================

# exe_vector_unit

Execute stage of the vector pipeline, directly downstream of the ID/EXE register. Operates on 32-bit vectors as four unsigned 8-bit lanes (lane 0 = bits [7:0]) and produces vector or scalar results for the EXE/MEM register. Single-cycle ops complete in one clock. VMUL and VDOT run lane-serially over four clocks and hold `stall_out` high to freeze upstream.

## Interface
Parameters:
- `LANES`, 4: number of 8-bit lanes. Fixed at 4; other values are unsupported.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `valid_in` in 1: instruction present on inputs.
- `opcode_in` in 4: operation select.
- `sel_op_in` in 1: operand B source. 0 = `vec2_in`; 1 = `sca1_in` broadcast to all lanes.
- `sel_int_in` in 1: 1 = `inmediato_in` broadcast as operand B; overrides `sel_op_in`.
- `vec1_in`, `vec2_in` in 32: vector operands.
- `sca1_in`, `inmediato_in`, `shift_in` in 8: scalar, immediate, shift amount.
- `dir_dest_in` in 3: destination register.
- `reg_wrv_in`, `reg_wrs_in` in 1: vector/scalar write-back enables.
- `stall_out` out 1: multicycle op in progress; upstream holds its inputs.
- `valid_out` out 1: result present.
- `result_out` out 32: vector result.
- `scalar_out` out 8: scalar result (VDOT).
- `dir_dest_out` out 3, `reg_wrv_out` out 1, `reg_wrs_out` out 1: forwarded with the result.

## Operation
- Opcodes:
  - 0 NOP
  - 1 VADD
  - 2 VSUB (A−B)
  - 3 VAND
  - 4 VOR
  - 5 VXOR
  - 6 VSHL
  - 7 VSHR (logical)
  - 8 VMUL (low 8 bits of each lane product)
  - 9 VDOT (sum of the four lane products, written to `scalar_out`)
  - 10–15 reserved: treated as NOP.
- Shifts: each lane shifted by `shift_in`; `shift_in` ≥ 8 gives lane = 0.
- An instruction is accepted at a posedge when `valid_in`=1, state is IDLE and `stall_out`=0.
- NOP/reserved: accepted, but produce `valid_out`=0.
- FSM states: IDLE, MUL, DOT.
  - IDLE → MUL/DOT on accepting opcode 8/9. Operands, B-select result, dest and enables are latched; lane counter is set to 0.
  - MUL/DOT: one lane per edge; the counter increments 0→3.
  - After processing lane 3 → IDLE, with the outputs registered on that same edge.
- VDOT accumulator: 8-bit; wraps unless saturation is enabled.
- When `valid_out`=0: `reg_wrv_out` and `reg_wrs_out` are forced to 0. `result_out`, `scalar_out` and `dir_dest_out` hold their last values.
- Inputs presented while `stall_out`=1 are ignored.
- Reset: every output goes to 0, state to IDLE, counter and accumulator to 0. Asserting reset during MUL/DOT aborts the op; no `valid_out` is produced for it.

## Timing
- Single-cycle op accepted at edge E0: outputs are updated at E0; `valid_out`=1 for one cycle, or stays 1 if back-to-back ops follow.
- Multicycle op accepted at E0:
  - `stall_out` rises at E0.
  - Lanes 0..3 are processed at E1..E4.
  - Outputs are updated at E4; `valid_out`=1 and `stall_out`=0 for the cycle after E4.
  - `valid_out`=0 during E0..E3.
  - The next instruction is accepted at E5 at the earliest.
- Multicycle latency: 4 clocks from accept to result; throughput is 1 op per 5 clocks.

## Configuration
- `EXE_SAT_EN` defined: unsigned saturation.
  - VADD clamps at 255.
  - VSUB clamps at 0.
  - VMUL lanes clamp at 255 when the product exceeds 255.
  - VDOT accumulator clamps at 255.
- `EXE_SAT_EN` undefined: all arithmetic wraps modulo 256.

## Structure
- Shared package `exe_pkg`: opcode localparams (`OP_NOP`..`OP_VDOT`), FSM state encoding, `LANE_W`=8.
- Sub-module `exe_lane_alu`: combinational 8-bit single-lane ALU (add/sub/logic/shift/mul, with saturation under the same macro). Instantiated 4× for single-cycle ops and reused, muxed by the lane counter, for the serial ops.

## Test plan
- VADD, `vec1`=0x01020304, `vec2`=0x10203040 → `result_out`=0x11223344, `valid_out` one cycle after accept, `stall_out` stays 0.
- VADD, `vec1`=0xFF000000, `vec2`=0x02000000 → 0x01000000 without `EXE_SAT_EN`; 0xFF000000 with it. VSUB 0x00000005 − 0x00000007 → 0x000000FE / 0x00000000 respectively.
- VMUL, `vec1`=0x02030405, `sca1`=3, `sel_op`=1 → `stall_out` high 4 cycles, then `result_out`=0x06090C0F with `valid_out` pulse. Inputs changed mid-op are ignored.
- VDOT, `vec1`=0x01020304, `vec2`=0x01010101 → `scalar_out`=0x0A, `reg_wrs_out` forwarded, `result_out` unchanged.
- VSHL, 0x01010101 with `shift_in`=3 → 0x08080808; with `shift_in`=9 → 0x00000000. Reserved opcode 12 → `valid_out`=0, `reg_wrv_out`=0.
- VMUL accepted, `rst_n` pulsed low at E2 → all outputs 0 immediately, state IDLE, no `valid_out`. A VADD accepted on the first edge after release completes normally.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the vector execute stage.
// Contents:
//   LANE_W      width of one vector lane (8 bits)
//   OP_*        opcode encodings (0..9, 10..15 reserved and treated as NOP)
//   state_t     FSM encoding for lane-serial operations
//   is_single_op() true for opcodes that complete in one clock
package exe_pkg;

    localparam int LANE_W = 8;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_VADD = 4'd1;
    localparam logic [3:0] OP_VSUB = 4'd2;
    localparam logic [3:0] OP_VAND = 4'd3;
    localparam logic [3:0] OP_VOR  = 4'd4;
    localparam logic [3:0] OP_VXOR = 4'd5;
    localparam logic [3:0] OP_VSHL = 4'd6;
    localparam logic [3:0] OP_VSHR = 4'd7;
    localparam logic [3:0] OP_VMUL = 4'd8;
    localparam logic [3:0] OP_VDOT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DOT  = 2'd2
    } state_t;

    function automatic logic is_single_op(input logic [3:0] op);
        return (op >= OP_VADD) && (op <= OP_VSHR);
    endfunction

endpackage

// File: rtl/exe_lane_alu.sv
// exe_lane_alu: combinational single-lane (8-bit, unsigned) ALU.
// Optional feature macro: EXE_SAT_EN (unsigned saturation of add/sub/mul).
// Ports:
//   op_i     opcode (exe_pkg OP_*); NOP/VDOT/reserved give 0, VDOT callers use OP_VMUL
//   a_i      lane operand A
//   b_i      lane operand B
//   shamt_i  shift amount; values >= 8 clear the lane
//   res_o    lane result
module exe_lane_alu
    import exe_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic [7:0]        shamt_i,
    output logic [LANE_W-1:0] res_o
);

    function automatic logic [LANE_W-1:0] add_lane(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
`ifdef EXE_SAT_EN
        logic [LANE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LANE_W] ? {LANE_W{1'b1}} : s[LANE_W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [LANE_W-1:0] sub_lane(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
`ifdef EXE_SAT_EN
        return (b > a) ? '0 : a - b;
`else
        return a - b;
`endif
    endfunction

    function automatic logic [LANE_W-1:0] mul_lane(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
`ifdef EXE_SAT_EN
        logic [2*LANE_W-1:0] p;
        p = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
        return (p[2*LANE_W-1:LANE_W] != '0) ? {LANE_W{1'b1}} : p[LANE_W-1:0];
`else
        return a * b;
`endif
    endfunction

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_VADD: res_o = add_lane(a_i, b_i);
            OP_VSUB: res_o = sub_lane(a_i, b_i);
            OP_VAND: res_o = a_i & b_i;
            OP_VOR:  res_o = a_i | b_i;
            OP_VXOR: res_o = a_i ^ b_i;
            OP_VSHL: res_o = (shamt_i >= 8'd8) ? '0 : (a_i << shamt_i[2:0]);
            OP_VSHR: res_o = (shamt_i >= 8'd8) ? '0 : (a_i >> shamt_i[2:0]);
            OP_VMUL: res_o = mul_lane(a_i, b_i);
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/exe_vector_unit.sv
// exe_vector_unit: execute stage of the vector pipeline (4 x 8-bit lanes).
// Single-cycle ops (VADD..VSHR) register their result on the accepting edge.
// VMUL/VDOT process one lane per clock over four clocks with stall_out high.
// Optional feature macro: EXE_SAT_EN (unsigned saturation; default wraps).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_in, opcode_in         instruction strobe and operation
//   sel_op_in, sel_int_in       operand-B source (vec2 / sca1 bcast / imm bcast)
//   vec1_in, vec2_in            vector operands
//   sca1_in, inmediato_in       scalar and immediate operands
//   shift_in                    shift amount
//   dir_dest_in, reg_wr*_in     destination and write enables to forward
//   stall_out                   multicycle op in progress
//   valid_out, result_out       vector result
//   scalar_out                  VDOT result
//   dir_dest_out, reg_wr*_out   forwarded with the result (enables gated by valid)
module exe_vector_unit
    import exe_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [3:0]  opcode_in,
    input  logic        sel_op_in,
    input  logic        sel_int_in,
    input  logic [31:0] vec1_in,
    input  logic [31:0] vec2_in,
    input  logic [7:0]  sca1_in,
    input  logic [7:0]  inmediato_in,
    input  logic [7:0]  shift_in,
    input  logic [2:0]  dir_dest_in,
    input  logic        reg_wrv_in,
    input  logic        reg_wrs_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] result_out,
    output logic [7:0]  scalar_out,
    output logic [2:0]  dir_dest_out,
    output logic        reg_wrv_out,
    output logic        reg_wrs_out
);

    // Control and output state
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  dest_q, dest_d;
    logic        wrv_lat_q, wrv_lat_d;
    logic        wrs_lat_q, wrs_lat_d;
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  scalar_q, scalar_d;
    logic [2:0]  dir_q, dir_d;
    logic        wrv_q, wrv_d;
    logic        wrs_q, wrs_d;

    // Latched operands and partial VMUL result (data only, no reset needed)
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] part_q, part_d;

    logic              busy;
    logic [31:0]       opb;
    logic [31:0]       a_sel, b_sel, alu_vec;
    logic [3:0]        op_sel;
    logic [LANE_W-1:0] alu_res [LANES];
    logic [LANE_W-1:0] lane_res;

    // VDOT accumulation; a clamped (255) VMUL lane under saturation forces 255
    function automatic logic [7:0] acc_add(input logic [7:0] acc, input logic [7:0] p);
`ifdef EXE_SAT_EN
        logic [8:0] s;
        s = {1'b0, acc} + {1'b0, p};
        return s[8] ? 8'hFF : s[7:0];
`else
        return acc + p;
`endif
    endfunction

    assign busy = (state_q != ST_IDLE);

    // sel_int_in takes priority over sel_op_in
    assign opb = sel_int_in ? {4{inmediato_in}} :
                 sel_op_in  ? {4{sca1_in}}      : vec2_in;

    // While serial, the lane ALUs see the latched operands in multiply mode
    assign op_sel = busy ? OP_VMUL : opcode_in;
    assign a_sel  = busy ? a_q : vec1_in;
    assign b_sel  = busy ? b_q : opb;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        exe_lane_alu u_lane_alu (
            .op_i    (op_sel),
            .a_i     (a_sel[i*LANE_W +: LANE_W]),
            .b_i     (b_sel[i*LANE_W +: LANE_W]),
            .shamt_i (shift_in),
            .res_o   (alu_res[i])
        );
        assign alu_vec[i*LANE_W +: LANE_W] = alu_res[i];
    end

    assign lane_res = alu_res[cnt_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dest_d    = dest_q;
        wrv_lat_d = wrv_lat_q;
        wrs_lat_d = wrs_lat_q;
        a_d       = a_q;
        b_d       = b_q;
        part_d    = part_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        scalar_d  = scalar_q;
        dir_d     = dir_q;
        wrv_d     = 1'b0;
        wrs_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (is_single_op(opcode_in)) begin
                        valid_d  = 1'b1;
                        result_d = alu_vec;
                        dir_d    = dir_dest_in;
                        wrv_d    = reg_wrv_in;
                        wrs_d    = reg_wrs_in;
                    end else if (opcode_in == OP_VMUL || opcode_in == OP_VDOT) begin
                        state_d   = (opcode_in == OP_VMUL) ? ST_MUL : ST_DOT;
                        cnt_d     = 2'd0;
                        acc_d     = 8'd0;
                        a_d       = vec1_in;
                        b_d       = opb;
                        dest_d    = dir_dest_in;
                        wrv_lat_d = reg_wrv_in;
                        wrs_lat_d = reg_wrs_in;
                    end
                end
            end

            ST_MUL: begin
                part_d[{cnt_q, 3'b000} +: LANE_W] = lane_res;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b1;
                    result_d = part_d;
                    dir_d    = dest_q;
                    wrv_d    = wrv_lat_q;
                    wrs_d    = wrs_lat_q;
                end
            end

            ST_DOT: begin
                acc_d = acc_add(acc_q, lane_res);
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b1;
                    scalar_d = acc_d;
                    dir_d    = dest_q;
                    wrv_d    = wrv_lat_q;
                    wrs_d    = wrs_lat_q;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            acc_q     <= 8'd0;
            dest_q    <= 3'd0;
            wrv_lat_q <= 1'b0;
            wrs_lat_q <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= 32'd0;
            scalar_q  <= 8'd0;
            dir_q     <= 3'd0;
            wrv_q     <= 1'b0;
            wrs_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dest_q    <= dest_d;
            wrv_lat_q <= wrv_lat_d;
            wrs_lat_q <= wrs_lat_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            scalar_q  <= scalar_d;
            dir_q     <= dir_d;
            wrv_q     <= wrv_d;
            wrs_q     <= wrs_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        part_q <= part_d;
    end

    assign stall_out    = busy;
    assign valid_out    = valid_q;
    assign result_out   = result_q;
    assign scalar_out   = scalar_q;
    assign dir_dest_out = dir_q;
    assign reg_wrv_out  = wrv_q;
    assign reg_wrs_out  = wrs_q;

endmodule

// File: tb/tb_exe_vector_unit.sv
// Testbench for exe_vector_unit: scoreboard of expected results pushed when an
// instruction is driven and popped when valid_out is seen.
module tb_exe_vector_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [3:0]  opcode_in;
    logic        sel_op_in, sel_int_in;
    logic [31:0] vec1_in, vec2_in;
    logic [7:0]  sca1_in, inmediato_in, shift_in;
    logic [2:0]  dir_dest_in;
    logic        reg_wrv_in, reg_wrs_in;
    logic        stall_out, valid_out;
    logic [31:0] result_out;
    logic [7:0]  scalar_out;
    logic [2:0]  dir_dest_out;
    logic        reg_wrv_out, reg_wrs_out;

    always #5 clk = ~clk;

    exe_vector_unit #(.LANES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .opcode_in    (opcode_in),
        .sel_op_in    (sel_op_in),
        .sel_int_in   (sel_int_in),
        .vec1_in      (vec1_in),
        .vec2_in      (vec2_in),
        .sca1_in      (sca1_in),
        .inmediato_in (inmediato_in),
        .shift_in     (shift_in),
        .dir_dest_in  (dir_dest_in),
        .reg_wrv_in   (reg_wrv_in),
        .reg_wrs_in   (reg_wrs_in),
        .stall_out    (stall_out),
        .valid_out    (valid_out),
        .result_out   (result_out),
        .scalar_out   (scalar_out),
        .dir_dest_out (dir_dest_out),
        .reg_wrv_out  (reg_wrv_out),
        .reg_wrs_out  (reg_wrs_out)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [7:0]  sca;
        logic [2:0]  dir;
        logic        wrv;
        logic        wrs;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] hold_res = 32'd0;
    logic [7:0]  hold_sca = 8'd0;
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one lane, written from the operation table
    function automatic logic [7:0] m_lane(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] sh);
        int x;
        case (op)
            4'd1: begin
                x = int'(a) + int'(b);
`ifdef EXE_SAT_EN
                if (x > 255) x = 255;
`endif
            end
            4'd2: begin
                x = int'(a) - int'(b);
`ifdef EXE_SAT_EN
                if (x < 0) x = 0;
`endif
            end
            4'd3: x = int'(a & b);
            4'd4: x = int'(a | b);
            4'd5: x = int'(a ^ b);
            4'd6: x = (sh >= 8) ? 0 : (int'(a) << sh);
            4'd7: x = (sh >= 8) ? 0 : (int'(a) >> sh);
            4'd8: begin
                x = int'(a) * int'(b);
`ifdef EXE_SAT_EN
                if (x > 255) x = 255;
`endif
            end
            default: x = 0;
        endcase
        return x[7:0];
    endfunction

    function automatic logic [7:0] m_dot(input logic [31:0] a, input logic [31:0] b);
        int tot;
        tot = 0;
        for (int l = 0; l < 4; l++) tot += int'(a[l*8 +: 8]) * int'(b[l*8 +: 8]);
`ifdef EXE_SAT_EN
        if (tot > 255) tot = 255;
`endif
        return tot[7:0];
    endfunction

    // Called just after a posedge with the DUT idle; returns just after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [7:0] sca, input logic [7:0] imm, input logic [7:0] sh,
                        input logic selop, input logic selint, input logic [2:0] dest,
                        input logic wrv, input logic wrs);
        logic [31:0] b, res;
        logic [7:0]  d;
        b = selint ? {4{imm}} : (selop ? {4{sca}} : v2);
        if (op >= 4'd1 && op <= 4'd8) begin
            for (int l = 0; l < 4; l++) res[l*8 +: 8] = m_lane(op, v1[l*8 +: 8], b[l*8 +: 8], sh);
            sb.push_back('{res: res, sca: hold_sca, dir: dest, wrv: wrv, wrs: wrs});
            hold_res = res;
        end else if (op == 4'd9) begin
            d = m_dot(v1, b);
            sb.push_back('{res: hold_res, sca: d, dir: dest, wrv: wrv, wrs: wrs});
            hold_sca = d;
        end
        opcode_in = op; vec1_in = v1; vec2_in = v2; sca1_in = sca; inmediato_in = imm;
        shift_in = sh; sel_op_in = selop; sel_int_in = selint; dir_dest_in = dest;
        reg_wrv_in = wrv; reg_wrs_in = wrs; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Counts stalled cycles until stall_out falls; drops valid_in before the next edge
    task automatic wait_idle(output int cnt, output logic v_end);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (stall_out) cnt++;
            else break;
        end
        v_end = valid_out;
        valid_in = 1'b0;
        if (stall_out) check("stall_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (valid_out) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_result", result_out, mon_e.res);
                    check("sb_scalar", {24'd0, scalar_out}, {24'd0, mon_e.sca});
                    check("sb_dir", {29'd0, dir_dest_out}, {29'd0, mon_e.dir});
                    check("sb_wrv", {31'd0, reg_wrv_out}, {31'd0, mon_e.wrv});
                    check("sb_wrs", {31'd0, reg_wrs_out}, {31'd0, mon_e.wrs});
                end
            end else begin
                check("idle_wrv", {31'd0, reg_wrv_out}, 32'd0);
                check("idle_wrs", {31'd0, reg_wrs_out}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic        v;
        logic [3:0]  rop;

        rst_n = 1'b0; valid_in = 1'b0; opcode_in = 4'd0; sel_op_in = 1'b0; sel_int_in = 1'b0;
        vec1_in = '0; vec2_in = '0; sca1_in = '0; inmediato_in = '0; shift_in = '0;
        dir_dest_in = '0; reg_wrv_in = 1'b0; reg_wrs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_stall", {31'd0, stall_out}, 32'd0);
        check("rst_result", result_out, 32'd0);
        check("rst_scalar", {24'd0, scalar_out}, 32'd0);
        check("rst_dir", {29'd0, dir_dest_out}, 32'd0);
        check("rst_wrv", {31'd0, reg_wrv_out}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // VADD basic
        send(4'd1, 32'h01020304, 32'h10203040, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        check("vadd_valid", {31'd0, valid_out}, 32'd1);
        check("vadd_stall", {31'd0, stall_out}, 32'd0);
        check("vadd_res", result_out, 32'h11223344);
        @(posedge clk); #1;

        // VADD / VSUB at the wrap/saturation boundary
        send(4'd1, 32'hFF000000, 32'h02000000, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
`ifdef EXE_SAT_EN
        check("vadd_sat", result_out, 32'hFF000000);
`else
        check("vadd_wrap", result_out, 32'h01000000);
`endif
        @(posedge clk); #1;
        send(4'd2, 32'h00000005, 32'h00000007, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
`ifdef EXE_SAT_EN
        check("vsub_sat", result_out, 32'h00000000);
`else
        check("vsub_wrap", result_out, 32'h000000FE);
`endif
        @(posedge clk); #1;

        // VMUL with scalar broadcast; garbage presented while stalled
        send(4'd8, 32'h02030405, 32'hAAAAAAAA, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        valid_in = 1'b1; opcode_in = 4'd1; vec1_in = 32'hDEADBEEF; sca1_in = 8'h77; dir_dest_in = 3'd7;
        wait_idle(cnt, v);
        check("vmul_stall_cycles", cnt, 32'd4);
        check("vmul_valid", {31'd0, v}, 32'd1);
        check("vmul_res", result_out, 32'h06090C0F);

        // VDOT: scalar result, vector result held
        send(4'd9, 32'h01020304, 32'h01010101, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1);
        wait_idle(cnt, v);
        check("vdot_stall_cycles", cnt, 32'd4);
        check("vdot_scalar", {24'd0, scalar_out}, 32'h0000000A);
        check("vdot_res_hold", result_out, 32'h06090C0F);

        // VDOT overflow boundary (1024: wraps to 0 or clamps to 255)
        send(4'd9, 32'h10101010, 32'h00000000, 8'h10, 8'd0, 8'd0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
        wait_idle(cnt, v);

        // Shifts, immediate operand path
        send(4'd6, 32'h01010101, 32'd0, 8'd0, 8'd0, 8'd3, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        check("vshl3", result_out, 32'h08080808);
        @(posedge clk); #1;
        send(4'd6, 32'h01010101, 32'd0, 8'd0, 8'd0, 8'd9, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        check("vshl9", result_out, 32'h00000000);
        @(posedge clk); #1;
        send(4'd3, 32'hF0F0F00F, 32'h0, 8'h3C, 8'hFF, 8'd0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);

        // Reserved opcode
        send(4'd12, 32'h12345678, 32'h11111111, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
        @(negedge clk);
        check("rsvd_valid", {31'd0, valid_out}, 32'd0);
        check("rsvd_wrv", {31'd0, reg_wrv_out}, 32'd0);
        @(posedge clk); #1;

        // Randomised mix, back-to-back single-cycle ops
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            send(rop, $urandom, $urandom, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 10)),
                 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            if (rop == 4'd8 || rop == 4'd9) begin
                wait_idle(cnt, v);
                check("rand_stall_cycles", cnt, 32'd4);
            end
        end
        @(negedge clk);
        @(posedge clk); #1;

        // Reset during VMUL aborts it
        send(4'd8, 32'h11111111, 32'd0, 8'd2, 8'd0, 8'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        hold_res = 32'd0;
        hold_sca = 8'd0;
        #1;
        check("abort_valid", {31'd0, valid_out}, 32'd0);
        check("abort_stall", {31'd0, stall_out}, 32'd0);
        check("abort_result", result_out, 32'd0);
        check("abort_scalar", {24'd0, scalar_out}, 32'd0);
        check("abort_dir", {29'd0, dir_dest_out}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(4'd1, 32'h01010101, 32'h02020202, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_valid", {31'd0, valid_out}, 32'd1);
        check("post_rst_res", result_out, 32'h03030303);
        repeat (6) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
